// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA sequencer.
// Select codes mirror the ULA Sel encoding.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] SEL_OP0 = 2'b00;
    localparam logic [1:0] SEL_OP1 = 2'b01;
    localparam logic [1:0] SEL_OP2 = 2'b10;
    localparam logic [1:0] SEL_OP3 = 2'b11;

    localparam int DATA_W_DEF = 4;
    localparam int SETTLE_W   = 4;

endpackage

// File: rtl/ula_sequencer.sv
// Issues commands to the combinational ULA, waits a settle time,
// captures Res/OVRF and returns them over a valid/ready response port.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_sel,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [1:0]        ula_sel,
    input  logic [DATA_W-1:0] ula_res,
    input  logic              ula_ovrf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_ovrf,
    output logic              ovrf_sticky,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DATA_W-1:0]   ula_a_q, ula_a_d;
    logic [DATA_W-1:0]   ula_b_q, ula_b_d;
    logic [1:0]          ula_sel_q, ula_sel_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   rsp_res_q, rsp_res_d;
    logic                rsp_ovrf_q, rsp_ovrf_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                capture;

    assign cmd_ready = (state_q == IDLE) && rst_n;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        ula_sel_d   = ula_sel_q;
        acc_d       = acc_q;
        rsp_res_d   = rsp_res_q;
        rsp_ovrf_d  = rsp_ovrf_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ula_a_d   = cmd_chain ? acc_q : cmd_a;
                    ula_b_d   = cmd_b;
                    ula_sel_d = cmd_sel;
                    settle_d  = SETTLE_INIT;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end else begin
                    capture     = 1'b1;
                    rsp_res_d   = ula_res;
                    acc_d       = ula_res;
                    rsp_ovrf_d  = ula_ovrf;
                    rsp_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a capture with overflow outranks a same-edge clear
        sticky_d = clr_sticky ? 1'b0 : sticky_q;
        if (capture && ula_ovrf) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            ula_sel_q   <= '0;
            acc_q       <= '0;
            rsp_res_q   <= '0;
            rsp_ovrf_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_sel_q   <= ula_sel_d;
            acc_q       <= acc_d;
            rsp_res_q   <= rsp_res_d;
            rsp_ovrf_q  <= rsp_ovrf_d;
            rsp_valid_q <= rsp_valid_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ula_a       = ula_a_q;
    assign ula_b       = ula_b_q;
    assign ula_sel     = ula_sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_res     = rsp_res_q;
    assign rsp_ovrf    = rsp_ovrf_q;
    assign ovrf_sticky = sticky_q;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Bench for ula_sequencer: directed scenarios plus random ops
// checked against a transaction-level model of the sequencer.
module tb_ula_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [3:0] cmd_a, cmd_b, ula_a, ula_b, ula_res, rsp_res;
    logic [1:0] cmd_sel, ula_sel;
    logic       ula_ovrf, rsp_valid, rsp_ready, rsp_ovrf;
    logic       ovrf_sticky, clr_sticky;
    logic [7:0] op_count;

    logic       s3_cmd_valid, s3_cmd_ready, s3_cmd_chain;
    logic [3:0] s3_cmd_a, s3_cmd_b, s3_ula_a, s3_ula_b, s3_ula_res, s3_rsp_res;
    logic [1:0] s3_cmd_sel, s3_ula_sel;
    logic       s3_ula_ovrf, s3_rsp_valid, s3_rsp_ready, s3_rsp_ovrf;
    logic       s3_ovrf_sticky, s3_clr_sticky;
    logic [7:0] s3_op_count;

    int errors = 0;
    int checks = 0;

    int         m_cnt;
    logic [3:0] m_acc;
    logic       m_sticky;

    always #5 clk = ~clk;

    ula_sequencer #(.DATA_W(4), .SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
        .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel),
        .ula_res(ula_res), .ula_ovrf(ula_ovrf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_ovrf(rsp_ovrf),
        .ovrf_sticky(ovrf_sticky), .clr_sticky(clr_sticky),
        .op_count(op_count)
    );

    ula_sequencer #(.DATA_W(4), .SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
        .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_sel(s3_cmd_sel),
        .cmd_chain(s3_cmd_chain),
        .ula_a(s3_ula_a), .ula_b(s3_ula_b), .ula_sel(s3_ula_sel),
        .ula_res(s3_ula_res), .ula_ovrf(s3_ula_ovrf),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_res(s3_rsp_res), .rsp_ovrf(s3_rsp_ovrf),
        .ovrf_sticky(s3_ovrf_sticky), .clr_sticky(s3_clr_sticky),
        .op_count(s3_op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the SETTLE_CYCLES=1 instance.
    task automatic op1(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel, input logic chain,
                       input logic [3:0] res, input logic ov,
                       input logic clr, input int hold);
        logic [3:0] exp_a;
        exp_a = chain ? m_acc : a;
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_chain = chain;
        step();
        cmd_valid = 1'b0; cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_sel = 2'($urandom); cmd_chain = 1'($urandom);
        chk("issue_ula_a", ula_a, exp_a);
        chk("issue_ula_b", ula_b, b);
        chk("issue_ula_sel", ula_sel, sel);
        chk("issue_rsp_valid", rsp_valid, 0);
        chk("issue_cmd_ready", cmd_ready, 0);
        ula_res = res; ula_ovrf = ov; clr_sticky = clr;
        step();
        clr_sticky = 1'b0; ula_res = 4'($urandom); ula_ovrf = 1'($urandom);
        m_acc = res;
        m_cnt = (m_cnt + 1) % 256;
        m_sticky = ov | (m_sticky & ~clr);
        chk("cap_rsp_valid", rsp_valid, 1);
        chk("cap_rsp_res", rsp_res, res);
        chk("cap_rsp_ovrf", rsp_ovrf, ov);
        chk("cap_sticky", ovrf_sticky, m_sticky);
        chk("cap_op_count", op_count, m_cnt);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_res", rsp_res, res);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_ula_a", ula_a, exp_a);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_ula_a_kept", ula_a, exp_a);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; cmd_chain = 0;
        ula_res = 0; ula_ovrf = 0; rsp_ready = 0; clr_sticky = 0;
        s3_cmd_valid = 0; s3_cmd_a = 0; s3_cmd_b = 0; s3_cmd_sel = 0;
        s3_cmd_chain = 0; s3_ula_res = 0; s3_ula_ovrf = 0;
        s3_rsp_ready = 0; s3_clr_sticky = 0;
        m_cnt = 0; m_acc = 0; m_sticky = 0;
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_outputs", {ula_a, ula_b, ula_sel, rsp_res, rsp_ovrf, ovrf_sticky}, 0);
        chk("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        step();

        // settle of three edges: only the value at E0+3 is captured
        s3_cmd_valid = 1'b1; s3_cmd_a = 4'h3; s3_cmd_b = 4'h4; s3_cmd_sel = 2'b10;
        step();
        s3_cmd_valid = 1'b0;
        chk("s3_ula_a", s3_ula_a, 4'h3);
        s3_ula_res = 4'h9; s3_ula_ovrf = 1'b1;
        step();
        chk("s3_e1_valid", s3_rsp_valid, 0);
        s3_ula_res = 4'h6; s3_ula_ovrf = 1'b1;
        step();
        chk("s3_e2_valid", s3_rsp_valid, 0);
        s3_ula_res = 4'hc; s3_ula_ovrf = 1'b0;
        step();
        s3_ula_res = 4'h1;
        chk("s3_e3_valid", s3_rsp_valid, 1);
        chk("s3_e3_res", s3_rsp_res, 4'hc);
        chk("s3_e3_ovrf", s3_rsp_ovrf, 0);
        chk("s3_sticky", s3_ovrf_sticky, 0);
        chk("s3_op_count", s3_op_count, 1);
        s3_rsp_ready = 1'b1;
        step();
        s3_rsp_ready = 1'b0;
        chk("s3_done_ready", s3_cmd_ready, 1);

        op1(4'b1010, 4'b0111, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 0);
        op1(4'b1111, 4'b0001, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b0, 5);
        op1(4'h5, 4'h2, 2'b11, 1'b0, 4'h7, 1'b1, 1'b1, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        m_sticky = 1'b0;
        chk("clr_alone", ovrf_sticky, 0);

        for (int n = 0; n < 40; n++) begin
            op1(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // reset while in ISSUE aborts the operation
        cmd_valid = 1'b1; cmd_a = 4'h8; cmd_b = 4'h8; cmd_sel = 2'b00; cmd_chain = 0;
        step();
        cmd_valid = 1'b0;
        ula_res = 4'hf; ula_ovrf = 1'b1;
        rst_n = 1'b0;
        step();
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_op_count", op_count, 0);
        chk("abort_outputs", {ula_a, ula_b, ula_sel, rsp_res, rsp_ovrf, ovrf_sticky}, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        m_cnt = 0; m_acc = 0; m_sticky = 0;
        step();
        chk("abort_rsp_after", rsp_valid, 0);

        op1(4'h9, 4'h3, 2'b01, 1'b1, 4'h4, 1'b0, 1'b0, 0);
        for (int n = 1; n < 256; n++) begin
            op1(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        chk("wrap_op_count", op_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Sequential front end that issues operations to the 4-bit combinational ULA and collects its results.
- Accepts commands over a valid/ready handshake, drives the ULA operand and select inputs, waits a fixed settle time, then captures Res/OVRF.
- Returns each result over a second valid/ready handshake.
- Keeps an accumulator for chained operations, a sticky overflow flag and an operation counter. It sits between the control logic and the ULA.

Parameters:
- DATA_W, 4, operand/result width; must match the ULA width.
- SETTLE_CYCLES, 1, number of clock edges between operand drive and result capture; legal range 1..15.
- CNT_W, 8, width of the operation counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  DATA_W  operand A; ignored when cmd_chain=1.
- cmd_b  in  DATA_W  operand B.
- cmd_sel  in  2  ULA operation select.
- cmd_chain  in  1  use the accumulator as operand A.
- ula_a  out  DATA_W  to ULA A.
- ula_b  out  DATA_W  to ULA B.
- ula_sel  out  2  to ULA Sel.
- ula_res  in  DATA_W  from ULA Res.
- ula_ovrf  in  1  from ULA OVRF.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_res  out  DATA_W  captured result.
- rsp_ovrf  out  1  captured overflow.
- ovrf_sticky  out  1  set by any captured overflow.
- clr_sticky  in  1  clears ovrf_sticky.
- op_count  out  CNT_W  completed captures, modulo 2^CNT_W.

Behaviour:
- Reset: every register clears at a rising edge with rst_n=0.
  - state=IDLE.
  - ula_a, ula_b, ula_sel, rsp_res, accumulator = 0.
  - rsp_valid, rsp_ovrf, ovrf_sticky = 0; op_count = 0.
- cmd_ready = (state==IDLE) && rst_n. It is combinational from registered state and is 0 while rst_n=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: an edge with cmd_valid && cmd_ready accepts the command (edge E0).
  - ula_a <= cmd_chain ? accumulator : cmd_a.
  - ula_b <= cmd_b; ula_sel <= cmd_sel.
  - settle counter <= SETTLE_CYCLES-1; state <= ISSUE.
- ISSUE: cmd_ready=0 and ula_* are held stable.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture at that edge:
    - rsp_res and accumulator <= ula_res; rsp_ovrf <= ula_ovrf.
    - rsp_valid <= 1; op_count <= op_count+1 (wraps to 0 from all-ones).
    - state <= RESP.
  - With SETTLE_CYCLES=1, capture is at E0+1 and rsp_valid is visible from E0+1 on.
- RESP: rsp_* are held stable until an edge with rsp_valid && rsp_ready; then rsp_valid <= 0 and state <= IDLE.
  - No new command is accepted in the same edge. The minimum command-to-command spacing is SETTLE_CYCLES+2 edges.
- ula_a, ula_b and ula_sel keep their last values in IDLE and RESP; they are not zeroed.
- ovrf_sticky:
  - Set at a capture edge with ula_ovrf=1.
  - Cleared at an edge with clr_sticky=1.
  - If both happen at the same edge, set wins.
- The accumulator changes only at capture. A chained command after reset uses 0.
- Reset mid-operation (ISSUE or RESP): the operation is aborted, no response is produced, and op_count is not incremented.
- cmd_* values during ISSUE/RESP are ignored. cmd_valid may stay high; the command is accepted on the first IDLE edge.

Decomposition:
- Package ula_pkg:
  - State enum: IDLE, ISSUE, RESP.
  - Select code constants: SEL_OP0=2'b00, SEL_OP1=2'b01, SEL_OP2=2'b10, SEL_OP3=2'b11.
  - Default DATA_W=4.
- No sub-module inside the sequencer; the settle counter and op counter are inline.
- The ULA is instantiated beside the sequencer by the parent. Benches may also drive ula_res/ula_ovrf directly from a model.

Test Plan:
1. Single op: reset, then cmd a=1010 b=0111 sel=01 chain=0. Expect ula_a=1010, ula_b=0111, ula_sel=01 after E0. With the bench driving ula_res=0001, ula_ovrf=1, expect at E0+1: rsp_valid=1, rsp_res=0001, rsp_ovrf=1, ovrf_sticky=1, op_count=1.
2. Chain: after scenario 1 completes, cmd a=1111 b=0001 sel=00 chain=1. Expect ula_a=0001 (accumulator), not 1111.
3. Backpressure: hold rsp_ready=0 for 5 cycles. Expect rsp_res and rsp_valid stable and cmd_ready=0 throughout. Release rsp_ready; expect IDLE and cmd_ready=1 one edge later.
4. Settle: SETTLE_CYCLES=3, change ula_res during cycles E0+1..E0+2. Expect only the value present at E0+3 captured.
5. Sticky priority: clr_sticky=1 on the same edge as a capture with ula_ovrf=1. Expect ovrf_sticky=1. A later clr_sticky alone gives 0.
6. Reset/wrap: assert rst_n=0 while in ISSUE. Expect all outputs 0, no rsp_valid, op_count=0. Then run 256 ops with CNT_W=8; expect op_count wraps to 0.
